// File: rtl/vga_timing_pkg.sv
// VGA raster timing defaults and the sync bundle carried down the delay line.
package vga_timing_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    localparam int H_TOTAL = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_bits_t;

    localparam sync_bits_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

    function automatic logic in_win(input logic [9:0] v, input int lo, input int len);
        return (v >= 10'(lo)) && (v < 10'(lo + len));
    endfunction

endpackage

// File: rtl/vga_scan_driver_clk_en_divider.sv
// Pixel-tick strobe: one Clk-wide pulse every CLK_DIV cycles.
module clk_en_divider #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_en
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    always_comb begin
        div_d = (div_q == LAST) ? '0 : div_q + DW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign pix_en = (div_q == LAST);

endmodule

// File: rtl/vga_scan_driver.sv
// Raster counter, renderer coordinate publisher and registered VGA pin driver.
import vga_timing_pkg::*;

module vga_scan_driver #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF,
    parameter int PIPE_LAT  = 0
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [3:0] Red,
    input  logic [3:0] Green,
    input  logic [3:0] Blue,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       pix_en,
    output logic       frame_start,
    output logic       vblank,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_de,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b
);

    localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int PL    = (PIPE_LAT > 0) ? PIPE_LAT : 1;

    logic [9:0]  hc_q, hc_d;
    logic [9:0]  vc_q, vc_d;
    sync_bits_t  raw, tap;
    sync_bits_t  pipe_q [PL];
    sync_bits_t  pipe_d [PL];
    sync_bits_t  out_q, out_d;
    logic [11:0] rgb_q, rgb_d;

    clk_en_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .pix_en (pix_en)
    );

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (pix_en) begin
            if (hc_q == 10'(H_TOT - 1)) begin
                hc_d = '0;
                vc_d = (vc_q == 10'(V_TOT - 1)) ? '0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
    end

    always_comb begin
        raw.de = (hc_q < 10'(H_VISIBLE)) && (vc_q < 10'(V_VISIBLE));
        raw.hs = !in_win(hc_q, H_VISIBLE + H_FP, H_SYNC);
        raw.vs = !in_win(vc_q, V_VISIBLE + V_FP, V_SYNC);
    end

    // Syncs ride the same delay as the renderer so colour and syncs stay aligned.
    always_comb begin
        pipe_d = pipe_q;
        if (pix_en) begin
            pipe_d[0] = raw;
            for (int k = 1; k < PL; k++) begin
                pipe_d[k] = pipe_q[k-1];
            end
        end
        tap = (PIPE_LAT == 0) ? raw : pipe_q[PL-1];
    end

    always_comb begin
        out_d = out_q;
        rgb_d = rgb_q;
        if (pix_en) begin
            out_d = tap;
            rgb_d = tap.de ? {Red, Green, Blue} : 12'h000;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hc_q  <= '0;
            vc_q  <= '0;
            out_q <= SYNC_IDLE;
            rgb_q <= '0;
            for (int k = 0; k < PL; k++) begin
                pipe_q[k] <= SYNC_IDLE;
            end
        end else begin
            hc_q   <= hc_d;
            vc_q   <= vc_d;
            out_q  <= out_d;
            rgb_q  <= rgb_d;
            pipe_q <= pipe_d;
        end
    end

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign vblank      = (vc_q >= 10'(V_VISIBLE));
    assign frame_start = pix_en && (hc_q == 10'(H_TOT - 1))
                                && (vc_q == 10'(V_TOT - 1));
    assign vga_hs      = out_q.hs;
    assign vga_vs      = out_q.vs;
    assign vga_de      = out_q.de;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];

endmodule
